// File: rtl/vc_demux_pkg.sv
// Shared definitions for vc_demux: flit type codes, flit field positions and FSM states.
// Imported by vc_demux; the field macros are used wherever din is decoded.
`ifndef VC_DEMUX_PKG_SV
`define VC_DEMUX_PKG_SV

// Most-significant bit of the 2-bit type field and of the VC-id field.
`define VCD_TYPE_MSB(dw) ((dw) - 1)
`define VCD_ID_MSB(dw)   ((dw) - 3)

package vc_demux_pkg;

  localparam int         FLIT_TYPE_W = 2;

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b01;
  localparam logic [1:0] FLIT_HEAD   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PACKET = 2'd1,
    ST_DROP   = 2'd2
  } state_e;

endpackage

`endif

// File: rtl/vc_out_reg.sv
// Single-entry valid/ready output register tagged with a VC index.
// The stored flit is broadcast; only the tagged VC sees valid.
module vc_out_reg #(
  parameter int VC         = 4,
  parameter int DATA_WIDTH = 32,
  parameter int VC_ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [VC_ID_W-1:0]    i_vc,
  input  logic [VC-1:0]         i_ready,
  output logic                  o_can_load,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [VC-1:0]         o_valid
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [VC_ID_W-1:0]    r_vc;
  logic [VC-1:0]         w_vc_onehot;
  logic                  w_drain;

  always_comb begin
    w_vc_onehot = '0;
    for (int v = 0; v < VC; v++) begin
      if (r_vc == VC_ID_W'(v)) w_vc_onehot[v] = 1'b1;
    end
  end

  assign o_valid    = r_valid ? w_vc_onehot : '0;
  assign w_drain    = |(o_valid & i_ready);
  // A drain and a load in the same cycle keep the stage full: full throughput.
  assign o_can_load = !r_valid || w_drain;
  assign o_data     = r_data;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      // NOTE: the data register is reset too, because doutVC must read zero out of reset.
      r_data  <= '0;
      r_vc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_vc    <= i_vc;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vc_demux.sv
// Steers flits from one valid/ready link into VC per-VC buffers, locking the head's VC until tail.
// Optional feature: define VC_DEMUX_STATS_EN to add flit_cnt / err_cnt statistics outputs.
module vc_demux
  import vc_demux_pkg::*;
#(
  parameter int VC         = 4,
  parameter int DATA_WIDTH = 32,
  parameter int VC_ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [VC*DATA_WIDTH-1:0] doutVC,
  output logic [VC-1:0]            doutVC_valid,
  input  logic [VC-1:0]            doutVC_ready,
  output logic [VC-1:0]            VCPlaneSelector,
`ifdef VC_DEMUX_STATS_EN
  output logic [15:0]              flit_cnt,
  output logic [7:0]               err_cnt,
`endif
  output logic                     err
);

  localparam logic [VC_ID_W:0] VC_LIMIT = (VC_ID_W + 1)'(VC);

  state_e                r_state, w_state_nxt;
  logic [VC_ID_W-1:0]    r_lock_id, w_lock_id_nxt;
  logic [VC-1:0]         r_sel, w_sel_nxt;
  logic                  r_err;

  logic [FLIT_TYPE_W-1:0] w_type;
  logic [VC_ID_W-1:0]     w_id;
  logic                   w_id_ok;
  logic [VC-1:0]          w_id_onehot;
  logic                   w_accept;
  logic                   w_can_load;
  logic                   w_load;
  logic [VC_ID_W-1:0]     w_load_vc;
  logic                   w_drop_err;
  logic [DATA_WIDTH-1:0]  w_data;

  assign w_type    = din[`VCD_TYPE_MSB(DATA_WIDTH) -: FLIT_TYPE_W];
  assign w_id      = din[`VCD_ID_MSB(DATA_WIDTH) -: VC_ID_W];
  assign w_id_ok   = {1'b0, w_id} < VC_LIMIT;
  // din_ready depends only on the output stage, never on din_valid.
  assign din_ready = !rst && w_can_load;
  assign w_accept  = din_valid && din_ready;

  always_comb begin
    w_id_onehot = '0;
    for (int v = 0; v < VC; v++) begin
      if (w_id == VC_ID_W'(v)) w_id_onehot[v] = 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    w_sel_nxt     = r_sel;
    w_load        = 1'b0;
    w_load_vc     = r_lock_id;
    w_drop_err    = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_type == FLIT_HEAD || w_type == FLIT_SINGLE) begin
            if (w_id_ok) begin
              w_load    = 1'b1;
              w_load_vc = w_id;
              if (w_type == FLIT_HEAD) begin
                w_lock_id_nxt = w_id;
                w_sel_nxt     = w_id_onehot;
                w_state_nxt   = ST_PACKET;
              end
            end else begin
              w_drop_err = 1'b1;
              // An out-of-range head poisons its whole packet up to the tail.
              if (w_type == FLIT_HEAD) w_state_nxt = ST_DROP;
            end
          end else begin
            w_drop_err = 1'b1;
          end
        end
        ST_PACKET: begin
          if (w_type == FLIT_BODY) begin
            w_load = 1'b1;
          end else if (w_type == FLIT_TAIL) begin
            w_load      = 1'b1;
            w_sel_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_drop_err = 1'b1;
          end
        end
        ST_DROP: begin
          if (w_type == FLIT_TAIL) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_sel_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lock_id <= '0;
      r_sel     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_sel     <= w_sel_nxt;
      r_err     <= w_drop_err;
    end
  end

  assign VCPlaneSelector = r_sel;
  assign err             = r_err;

  vc_out_reg #(
    .VC         (VC),
    .DATA_WIDTH (DATA_WIDTH),
    .VC_ID_W    (VC_ID_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_data     (din),
    .i_vc       (w_load_vc),
    .i_ready    (doutVC_ready),
    .o_can_load (w_can_load),
    .o_data     (w_data),
    .o_valid    (doutVC_valid)
  );

  assign doutVC = {VC{w_data}};

`ifdef VC_DEMUX_STATS_EN
  logic [15:0] r_flit_cnt;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flit_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_load) r_flit_cnt <= r_flit_cnt + 16'd1;
      if (w_drop_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign flit_cnt = r_flit_cnt;
  assign err_cnt  = r_err_cnt;
`endif

endmodule

// File: tb/tb_vc_demux.sv
// Directed self-checking bench for vc_demux (VC=4, VC_ID_W=3 so out-of-range ids can be sent).
// Statistics checks run only when VC_DEMUX_STATS_EN is defined.
module tb_vc_demux;

  localparam int VC         = 4;
  localparam int DATA_WIDTH = 32;
  localparam int VC_ID_W    = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [DATA_WIDTH-1:0]    din;
  logic                     din_valid;
  logic                     din_ready;
  logic [VC*DATA_WIDTH-1:0] doutVC;
  logic [VC-1:0]            doutVC_valid;
  logic [VC-1:0]            doutVC_ready;
  logic [VC-1:0]            VCPlaneSelector;
  logic                     err;
`ifdef VC_DEMUX_STATS_EN
  logic [15:0]              flit_cnt;
  logic [7:0]               err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vc_demux #(
    .VC         (VC),
    .DATA_WIDTH (DATA_WIDTH),
    .VC_ID_W    (VC_ID_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .din             (din),
    .din_valid       (din_valid),
    .din_ready       (din_ready),
    .doutVC          (doutVC),
    .doutVC_valid    (doutVC_valid),
    .doutVC_ready    (doutVC_ready),
    .VCPlaneSelector (VCPlaneSelector),
`ifdef VC_DEMUX_STATS_EN
    .flit_cnt        (flit_cnt),
    .err_cnt         (err_cnt),
`endif
    .err             (err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {type[1:0], id[2:0], payload[26:0]}
  function automatic logic [31:0] flit(input logic [1:0] t, input logic [2:0] id, input logic [26:0] p);
    return {t, id, p};
  endfunction

  function automatic logic [31:0] slice(input int v);
    return doutVC[v*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] f);
    din       = f;
    din_valid = 1'b1;
  endtask

  logic [31:0] f_head, f_b1, f_b2, f_tail, f_s1, f_s3;

  initial begin
    rst          = 1'b1;
    din          = '0;
    din_valid    = 1'b1;
    doutVC_ready = 4'hF;
    step();
    step();
    check("rst_din_ready", din_ready, 0);
    check("rst_valid", doutVC_valid, 0);
    check("rst_dout", doutVC, 0);
    check("rst_sel", VCPlaneSelector, 0);
    check("rst_err", err, 0);
    din_valid = 1'b0;
    rst       = 1'b0;
    step();

    // Packet on VC2, full throughput.
    f_head = flit(2'b10, 3'd2, 27'h11);
    f_b1   = flit(2'b00, 3'd0, 27'h22);
    f_b2   = flit(2'b00, 3'd7, 27'h33);
    f_tail = flit(2'b01, 3'd1, 27'h44);
    drive(f_head);
    #1 check("p_ready", din_ready, 1);
    step();
    check("p_head_valid", doutVC_valid, 4'b0100);
    check("p_head_data", slice(2), f_head);
    check("p_head_sel", VCPlaneSelector, 4'b0100);
    drive(f_b1);
    step();
    check("p_b1_valid", doutVC_valid, 4'b0100);
    check("p_b1_data", slice(2), f_b1);
    check("p_b1_err", err, 0);
    drive(f_b2);
    step();
    check("p_b2_valid", doutVC_valid, 4'b0100);
    check("p_b2_data", slice(2), f_b2);
    check("p_b2_sel", VCPlaneSelector, 4'b0100);
    drive(f_tail);
    step();
    check("p_tail_valid", doutVC_valid, 4'b0100);
    check("p_tail_data", slice(2), f_tail);
    check("p_tail_sel", VCPlaneSelector, 0);
    check("p_tail_err", err, 0);
    din_valid = 1'b0;
    step();
    check("p_drained", doutVC_valid, 0);

    // Back-to-back SINGLE flits on VC1 then VC3.
    f_s1 = flit(2'b11, 3'd1, 27'h101);
    f_s3 = flit(2'b11, 3'd3, 27'h303);
    drive(f_s1);
    step();
    check("s1_valid", doutVC_valid, 4'b0010);
    check("s1_data", slice(1), f_s1);
    check("s1_sel", VCPlaneSelector, 0);
    drive(f_s3);
    step();
    check("s3_valid", doutVC_valid, 4'b1000);
    check("s3_data", slice(3), f_s3);
    check("s3_sel", VCPlaneSelector, 0);
    din_valid = 1'b0;
    step();

    // Backpressure on VC0 for three cycles.
    doutVC_ready = 4'b1110;
    f_head = flit(2'b10, 3'd0, 27'h55);
    f_b1   = flit(2'b00, 3'd0, 27'h66);
    f_tail = flit(2'b01, 3'd0, 27'h77);
    drive(f_head);
    step();
    drive(f_b1);
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", din_ready, 0);
      check("bp_valid", doutVC_valid, 4'b0001);
      check("bp_data", slice(0), f_head);
      step();
    end
    doutVC_ready = 4'hF;
    #1 check("bp_release_ready", din_ready, 1);
    step();
    check("bp_body_data", slice(0), f_b1);
    check("bp_body_valid", doutVC_valid, 4'b0001);
    drive(f_tail);
    step();
    check("bp_tail_data", slice(0), f_tail);
    din_valid = 1'b0;
    step();

    // Malformed traffic: BODY in IDLE, then out-of-range HEAD packet.
    drive(flit(2'b00, 3'd0, 27'h1));
    step();
    check("m_body_err", err, 1);
    check("m_body_valid", doutVC_valid, 0);
    drive(flit(2'b10, 3'd5, 27'h2));
    #1 check("m_head_ready", din_ready, 1);
    step();
    check("m_head_err", err, 1);
    check("m_head_valid", doutVC_valid, 0);
    check("m_head_sel", VCPlaneSelector, 0);
    drive(flit(2'b00, 3'd0, 27'h3));
    step();
    check("m_drop_body_err", err, 0);
    check("m_drop_body_valid", doutVC_valid, 0);
    drive(flit(2'b01, 3'd0, 27'h4));
    step();
    check("m_drop_tail_err", err, 0);
    check("m_drop_tail_valid", doutVC_valid, 0);
    f_s1 = flit(2'b11, 3'd0, 27'h5);
    drive(f_s1);
    step();
    check("m_idle_again", doutVC_valid, 4'b0001);
    check("m_idle_data", slice(0), f_s1);
    din_valid = 1'b0;
    step();

    // Reset mid-packet.
    f_head = flit(2'b10, 3'd1, 27'hA1);
    drive(f_head);
    step();
    drive(flit(2'b00, 3'd0, 27'hA2));
    step();
    check("r_pkt_sel", VCPlaneSelector, 4'b0010);
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("r_async_valid", doutVC_valid, 0);
    check("r_async_dout", doutVC, 0);
    check("r_async_sel", VCPlaneSelector, 0);
    check("r_async_ready", din_ready, 0);
    step();
    rst = 1'b0;
    drive(flit(2'b01, 3'd0, 27'hA3));
    step();
    check("r_tail_err", err, 1);
    check("r_tail_valid", doutVC_valid, 0);
    din_valid = 1'b0;
    step();

`ifdef VC_DEMUX_STATS_EN
    // Since the reset above: 0 flits written, 1 drop.
    for (int i = 0; i < 5; i++) begin
      drive(flit(2'b11, 3'(i % 4), 27'(i)));
      step();
    end
    drive(flit(2'b01, 3'd0, 27'h0));
    step();
    din_valid = 1'b0;
    step();
    check("st_flit_cnt", flit_cnt, 16'd5);
    check("st_err_cnt", err_cnt, 8'd2);
    drive(flit(2'b00, 3'd0, 27'h0));
    for (int i = 0; i < 300; i++) step();
    din_valid = 1'b0;
    step();
    check("st_err_sat", err_cnt, 8'hFF);
    check("st_flit_hold", flit_cnt, 16'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_demux.md
Name: vc_demux

Overview:
- Input-side counterpart of the VC output multiplexer. Takes flits arriving from a link or switch port over a single valid/ready channel and steers each flit into one of VC virtual-channel input buffers.
- The head flit's VC-id field selects the VC. That VC stays locked until the tail flit.
- One registered output stage; sits between the link receiver and the per-VC buffers of a router input port.

Parameters:
- VC, 4, number of virtual channels (>=2).
- DATA_WIDTH, 32, flit width including type and VC-id fields.
- VC_ID_W, 2, width of VC-id field; must satisfy 2**VC_ID_W >= VC.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  incoming flit.
- din_valid  input  1  flit on din is valid.
- din_ready  output  1  demux accepts flit this cycle.
- doutVC  output  VC*DATA_WIDTH  flit to buffers; slice v belongs to VC v; all slices carry the same registered flit.
- doutVC_valid  output  VC  per-VC valid; at most one bit set.
- doutVC_ready  input  VC  per-VC buffer has space.
- VCPlaneSelector  output  VC  one-hot VC currently locked; 0 when idle.
- err  output  1  one-cycle pulse on a dropped malformed flit.

Behaviour:
- Flit format: din[DATA_WIDTH-1:DATA_WIDTH-2] is the type field: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE (head+tail).
- VC id = din[DATA_WIDTH-3 -: VC_ID_W]; the field is meaningful on HEAD and SINGLE flits only.
- Reset (async, immediate): state IDLE, output register empty, doutVC_valid=0, doutVC=0, VCPlaneSelector=0, err=0, din_ready=0 while rst is high.
- Handshake rules:
  - A transfer occurs when din_valid && din_ready.
  - An output transfer on VC v occurs when doutVC_valid[v] && doutVC_ready[v].
  - din_ready = !rst && (out reg empty || output transfer this cycle). This is combinational from doutVC_ready, with no combinational path from din_valid.
  - An accepted flit appears on doutVC the next cycle (latency 1). Back-to-back accept and drain gives full throughput.
  - doutVC and doutVC_valid hold stable while valid && !ready.
- FSM:
  - IDLE: HEAD with id<VC → latch id, go to PACKET, write flit to reg for that VC. SINGLE with id<VC → write flit, stay IDLE, no lock.
  - IDLE: BODY or TAIL → drop, pulse err, stay IDLE.
  - IDLE: HEAD or SINGLE with id>=VC → drop, pulse err. For HEAD, go to DROP.
  - PACKET: BODY → write to the locked VC. TAIL → write, then go to IDLE. HEAD or SINGLE → drop, pulse err, stay PACKET; the id field is ignored.
  - DROP: discard BODY. TAIL → discard, go to IDLE. Dropped flits still assert din_ready whenever it would otherwise be high, so the link never stalls on garbage.
- VCPlaneSelector is one-hot of the locked id in PACKET, 0 in IDLE and DROP. It updates on the accepting edge.
- Dropped flits never set doutVC_valid.
- Simultaneous drain and accept: the register reloads in the same edge; valid stays high, and the VC may change.
- A reset mid-packet discards the lock and the register contents; a later BODY or TAIL is then dropped as malformed.

Optional Feature:
- VC_DEMUX_STATS_EN defined adds:
  - Output flit_cnt [15:0]: counts flits written to the register; wraps at 16'hFFFF→0.
  - Output err_cnt [7:0]: counts dropped malformed flits; saturates at 8'hFF.
  - Both counters reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/include holds:
  - flit type localparams FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE;
  - field-position macros for type and VC-id;
  - FSM state encodings ST_IDLE, ST_PACKET, ST_DROP.
- One natural sub-module, vc_out_reg: a single-entry valid/ready register with a VC tag. The FSM stays in vc_demux.

Test Plan:
- HEAD(id=2), BODY, BODY, TAIL, all doutVC_ready=1 → flits appear on VC2 one cycle after each accept. VCPlaneSelector=4'b0100 during the packet, 0 after TAIL. err never pulses.
- SINGLE(id=1) then SINGLE(id=3) on consecutive cycles → doutVC_valid = 4'b0010 then 4'b1000. VCPlaneSelector stays 0.
- HEAD(id=0) with doutVC_ready[0]=0 for 3 cycles → din_ready=0 and doutVC stable for 3 cycles. On release, the next flit is accepted the same cycle.
- BODY in IDLE, then HEAD(id=5) with VC=4 and VC_ID_W=3, followed by BODY and TAIL → two err pulses. No doutVC_valid for any of these flits. FSM returns to IDLE after TAIL.
- Reset asserted mid-packet after HEAD(id=1), BODY → outputs clear immediately. A following TAIL pulses err.
- With VC_DEMUX_STATS_EN: 5 valid flits plus 2 malformed flits → flit_cnt=5, err_cnt=2. A forced error storm of 300 drops → err_cnt=8'hFF.
